e_mdu: RTL

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 97 +++++++++
 1 files changed

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers for the E stage
module e_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdOut
);
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d, op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_s, prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0] quo_u, rem_u;
  logic        ovf;

  assign busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

  // issue handshake and mfhi/mflo read port
  always_comb begin
    start = (mdOp >= OP_MULT) && (mdOp <= OP_DIVU) && !busy_q && !req;
    mdOut = (mdOp == OP_MFHI) ? hi_q : (mdOp == OP_MFLO) ? lo_q : 32'd0;
  end

  // arithmetic on latched operands only; the most-negative / -1 case is pinned explicitly
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    ovf    = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    quo_s  = (b_q == 32'd0 || ovf) ? $signed(a_q) : $signed(a_q) / $signed(b_q);
    rem_s  = (b_q == 32'd0 || ovf) ? 32'sd0 : $signed(a_q) % $signed(b_q);
    quo_u  = (b_q == 32'd0) ? 32'd0 : a_q / b_q;
    rem_u  = (b_q == 32'd0) ? 32'd0 : a_q % b_q;
  end

  // next state: accept, count down, retire into HI/LO, or direct HI/LO writes
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start) begin
      a_d    = A;
      b_d    = B;
      op_d   = mdOp;
      cnt_d  = (mdOp <= OP_MULTU) ? 4'd5 : 4'd10;
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        if (op_q == OP_MULT) {hi_d, lo_d} = prod_s;
        else if (op_q == OP_MULTU) {hi_d, lo_d} = prod_u;
        else if (op_q == OP_DIV && b_q != 32'd0) {hi_d, lo_d} = {rem_s, quo_s};
        else if (op_q == OP_DIVU && b_q != 32'd0) {hi_d, lo_d} = {rem_u, quo_u};
      end
    end else if (!req) begin
      if (mdOp == OP_MTHI) hi_d = A;
      if (mdOp == OP_MTLO) lo_d = A;
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= 4'd0;
      op_q   <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end
endmodule
